// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of the shared serial bus.
// One master wins at a time. Its target slave id and direction are latched when it wins.
// Grant and one-hot slave enables stay asserted until the addressed slave reports done.
// A one-cycle turnaround gap always follows the release of the bus.
// Optional build macro ARB_TIMEOUT_EN adds a BUSY watchdog that revokes a stuck grant.
module bus_arbiter #(
   parameter int N_MASTERS = 2,
   parameter int N_SLAVES  = 3,
   parameter int SID_W     = 2,
   parameter int TIMEOUT   = 4095
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_MASTERS-1:0]       m_req,
   input  logic [N_MASTERS-1:0]       m_write,
   input  logic [N_MASTERS*SID_W-1:0] m_slave_id,
   input  logic [N_SLAVES-1:0]        s_done,
   output logic [N_MASTERS-1:0]       m_grant,
   output logic [N_SLAVES-1:0]        s_read_en,
   output logic [N_SLAVES-1:0]        s_write_en,
   output logic                       bus_busy,
   output logic                       decode_err,
   output logic                       timeout_err
);

   localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

   // Reject configurations whose id field cannot address every slave
   if (((1 << SID_W) < N_SLAVES) || (TIMEOUT < 1)) begin : g_param_check
      $error("bus_arbiter: inconsistent parameters");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_BUSY  = 2'd2,
      ST_GAP   = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 write_q, write_d;
   logic [SID_W-1:0]     sid_q, sid_d;
   logic [N_MASTERS-1:0] grant_q, grant_d;
   logic [N_SLAVES-1:0]  rd_en_q, rd_en_d;
   logic [N_SLAVES-1:0]  wr_en_q, wr_en_d;
   logic                 busy_q, busy_d;
   logic                 dec_err_q, dec_err_d;
   logic                 tout_d;

   logic                 win_found_s;
   logic                 hit_s;
   logic [IDX_W-1:0]     win_idx_s;
   logic                 done_s;
   logic                 active_s;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc_s;
   logic                 tout_q;
`endif

   // Master index base+off, wrapped modulo N_MASTERS
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      s = (s >= N_MASTERS) ? (s - N_MASTERS) : s;
      return IDX_W'(s);
   endfunction

   // True when the id addresses an existing slave
   function automatic logic sid_ok(input logic [SID_W-1:0] id);
      return (int'(id) < N_SLAVES);
   endfunction

   // One-hot master vector for an index
   function automatic logic [N_MASTERS-1:0] onehot_m(input logic [IDX_W-1:0] idx);
      logic [N_MASTERS-1:0] oh;
      for (int j = 0; j < N_MASTERS; j++) begin
         oh[j] = (int'(idx) == j);
      end
      return oh;
   endfunction

   // One-hot slave vector for an id; out-of-range ids give all zeros
   function automatic logic [N_SLAVES-1:0] onehot_s(input logic [SID_W-1:0] id);
      logic [N_SLAVES-1:0] oh;
      for (int j = 0; j < N_SLAVES; j++) begin
         oh[j] = (int'(id) == j);
      end
      return oh;
   endfunction

   // Round-robin search: first requester at or after the priority pointer
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = '0;
      hit_s       = 1'b0;
      for (int k = 0; k < N_MASTERS; k++) begin
         hit_s       = m_req[wrap_add(ptr_q, k)] & ~win_found_s;
         win_idx_s   = hit_s ? wrap_add(ptr_q, k) : win_idx_s;
         win_found_s = win_found_s | hit_s;
      end
   end

   // Completion is only honoured from the slave that owns the transfer
   always_comb begin
      done_s = |(s_done & onehot_s(sid_q));
   end

`ifdef ARB_TIMEOUT_EN
   // Watchdog counts BUSY cycles and is held at zero outside BUSY
   always_comb begin
      cnt_inc_s = cnt_q + CNT_W'(1);
      cnt_d     = (state_q == ST_BUSY) ? cnt_inc_s : '0;
   end
`endif

   // Next-state logic, transfer latching and pointer advance
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      write_d = write_q;
      sid_d   = sid_q;
      tout_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (win_found_s) begin
               state_d = ST_GRANT;
               idx_d   = win_idx_s;
               write_d = m_write[win_idx_s];
               sid_d   = m_slave_id[int'(win_idx_s)*SID_W +: SID_W];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (sid_ok(sid_q)) begin
               state_d = ST_BUSY;
            end else begin
               state_d = ST_GAP;
            end
         end
         ST_BUSY: begin
            if (done_s) begin
               state_d = ST_GAP;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_inc_s == CNT_W'(TIMEOUT)) begin
               state_d = ST_GAP;
               tout_d  = 1'b1;
            end
`endif
            else begin
               state_d = ST_BUSY;
            end
         end
         ST_GAP: begin
            state_d = ST_IDLE;
            ptr_d   = (int'(idx_q) == (N_MASTERS - 1)) ? '0 : (idx_q + IDX_W'(1));
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output values for the state being entered, so the outputs come straight from registers
   always_comb begin
      active_s  = (state_d == ST_GRANT) || (state_d == ST_BUSY);
      grant_d   = active_s ? onehot_m(idx_d) : '0;
      rd_en_d   = (active_s && !write_d) ? onehot_s(sid_d) : '0;
      wr_en_d   = (active_s && write_d) ? onehot_s(sid_d) : '0;
      busy_d    = active_s;
      dec_err_d = (state_d == ST_GRANT) && !sid_ok(sid_d);
   end

   // State, latched transfer and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         idx_q     <= '0;
         write_q   <= 1'b0;
         sid_q     <= '0;
         grant_q   <= '0;
         rd_en_q   <= '0;
         wr_en_q   <= '0;
         busy_q    <= 1'b0;
         dec_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         write_q   <= write_d;
         sid_q     <= sid_d;
         grant_q   <= grant_d;
         rd_en_q   <= rd_en_d;
         wr_en_q   <= wr_en_d;
         busy_q    <= busy_d;
         dec_err_q <= dec_err_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   // Watchdog counter and its expiry pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         tout_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tout_q <= tout_d;
      end
   end
   assign timeout_err = tout_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign m_grant    = grant_q;
   assign s_read_en  = rd_en_q;
   assign s_write_en = wr_en_q;
   assign bus_busy   = busy_q;
   assign decode_err = dec_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by random traffic.
// Every cycle is compared against a transaction-level ownership model.
module tb_bus_arbiter;

   localparam int NM = 2;
   localparam int NS = 3;
   localparam int SW = 2;
`ifdef ARB_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 4095;
`endif

   logic             clk;
   logic             reset;
   logic [NM-1:0]    m_req;
   logic [NM-1:0]    m_write;
   logic [NM*SW-1:0] m_slave_id;
   logic [NS-1:0]    s_done;
   logic [NM-1:0]    m_grant;
   logic [NS-1:0]    s_read_en;
   logic [NS-1:0]    s_write_en;
   logic             bus_busy;
   logic             decode_err;
   logic             timeout_err;

   int vectors;
   int miscompares;

   // Ownership model: who holds the bus, for how long, and the pending gap
   int owner;
   int age;
   int hid;
   bit hwr;
   bit cool;
   int last;
   int ptr;
   bit tout;

   bus_arbiter #(.N_MASTERS(NM), .N_SLAVES(NS), .SID_W(SW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .m_req(m_req), .m_write(m_write),
      .m_slave_id(m_slave_id), .s_done(s_done), .m_grant(m_grant),
      .s_read_en(s_read_en), .s_write_en(s_write_en), .bus_busy(bus_busy),
      .decode_err(decode_err), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      owner = -1; age = 0; hid = 0; hwr = 1'b0;
      cool = 1'b0; last = 0; ptr = 0; tout = 1'b0;
   endtask

   task automatic release_bus();
      last  = owner;
      owner = -1;
      cool  = 1'b1;
   endtask

   // Advance the model by one clock using the inputs present at the edge
   task automatic model_tick();
      bit found;
      int c;
      tout = 1'b0;
      if (owner >= 0) begin
         if (age == 0 && hid >= NS) release_bus();
         else if (age > 0 && s_done[hid]) release_bus();
`ifdef ARB_TIMEOUT_EN
         else if (age == TO) begin release_bus(); tout = 1'b1; end
`endif
         else age++;
      end else if (cool) begin
         cool = 1'b0;
         ptr  = (last + 1) % NM;
      end else if (m_req != '0) begin
         found = 1'b0;
         for (int k = 0; k < NM; k++) begin
            c = (ptr + k) % NM;
            if (!found && m_req[c]) begin
               found = 1'b1;
               owner = c;
            end
         end
         hid = int'(m_slave_id[owner*SW +: SW]);
         hwr = m_write[owner];
         age = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [NM-1:0] eg;
      logic [NS-1:0] er, ew;
      eg = '0; er = '0; ew = '0;
      if (owner >= 0) begin
         eg[owner] = 1'b1;
         if (hid < NS) begin
            if (hwr) ew[hid] = 1'b1;
            else     er[hid] = 1'b1;
         end
      end
      chk({tag, ".grant"},   8'(m_grant),     8'(eg));
      chk({tag, ".rd_en"},   8'(s_read_en),   8'(er));
      chk({tag, ".wr_en"},   8'(s_write_en),  8'(ew));
      chk({tag, ".busy"},    8'(bus_busy),    8'(owner >= 0));
      chk({tag, ".dec_err"}, 8'(decode_err),  8'(owner >= 0 && age == 0 && hid >= NS));
      chk({tag, ".tout"},    8'(timeout_err), 8'(tout));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_tick();
      #1;
      check_all(tag);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      model_reset();
      reset = 1'b0; m_req = '0; m_write = '0; m_slave_id = '0; s_done = '0;
      #3 check_all("reset");
      #9 reset = 1'b1;

      // Master 0 writes slave 2
      m_req = 2'b01; m_write = 2'b01; m_slave_id = {2'd0, 2'd2};
      step("wr_grant");
      m_req = 2'b00;
      step("wr_busy");
      step("wr_hold");
      s_done = 3'b100;
      step("wr_done");
      s_done = 3'b000;
      step("wr_idle");
      step("wr_idle2");

      // Both masters read slave 1; grants alternate
      m_req = 2'b11; m_write = 2'b00; m_slave_id = {2'd1, 2'd1};
      for (int i = 0; i < 16; i++) begin
         s_done = (i % 3 == 2) ? 3'b010 : 3'b000;
         step("rr");
      end
      m_req = 2'b00; s_done = 3'b010;
      for (int i = 0; i < 6; i++) step("rr_drain");
      s_done = 3'b000;
      for (int i = 0; i < 3; i++) step("rr_idle");

      // Foreign done pulses are ignored
      m_req = 2'b01; m_write = 2'b00; m_slave_id = {2'd0, 2'd0};
      step("own_grant");
      m_req = 2'b00;
      step("own_busy");
      s_done = 3'b110;
      step("own_foreign");
      step("own_foreign2");
      s_done = 3'b001;
      step("own_done");
      s_done = 3'b000;
      for (int i = 0; i < 3; i++) step("own_idle");

      // Undecodable slave id
      m_req = 2'b01; m_slave_id = {2'd0, 2'd3};
      step("dec_grant");
      m_req = 2'b00;
      step("dec_gap");
      for (int i = 0; i < 2; i++) step("dec_idle");

      // Asynchronous reset in the middle of a transfer
      m_req = 2'b01; m_write = 2'b01; m_slave_id = {2'd0, 2'd2};
      step("ar_grant");
      step("ar_busy");
      #2 reset = 1'b0;
      #1 model_reset();
      check_all("async_rst");
      #2 reset = 1'b1;
      m_req = 2'b10; m_write = 2'b00; m_slave_id = {2'd1, 2'd0};
      step("ar_m1_grant");
      m_req = 2'b00;
      step("ar_m1_busy");
      s_done = 3'b010;
      step("ar_m1_done");
      s_done = 3'b000;
      for (int i = 0; i < 2; i++) step("ar_idle");

      // No done: watchdog expiry, or an indefinite hold without it
      m_req = 2'b01; m_write = 2'b00; m_slave_id = {2'd0, 2'd1};
      step("hold_grant");
      m_req = 2'b00;
      for (int i = 0; i < 110; i++) step("hold");
      s_done = 3'b010;
      step("hold_done");
      s_done = 3'b000;
      for (int i = 0; i < 3; i++) step("hold_idle");

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         m_req      = NM'($urandom_range(0, 3));
         m_write    = NM'($urandom_range(0, 3));
         m_slave_id = (NM*SW)'($urandom_range(0, 15));
         for (int j = 0; j < NS; j++) s_done[j] = ($urandom_range(0, 2) == 0);
         step("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Shares the serial system bus between N_MASTERS masters and N_SLAVES slave blocks. Arbitrates master requests round-robin and latches the winner's target slave id and direction. Drives the one-hot grant to masters and the one-hot read_en/write_en to slaves. Holds the bus until the addressed slave reports completion, then inserts a one-cycle turnaround gap.

Parameters:
N_MASTERS, 2, number of requesting masters (2..4)
N_SLAVES, 3, number of slaves (1..4)
SID_W, 2, slave id width per master; must satisfy 2^SID_W >= N_SLAVES
TIMEOUT, 4095, watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  bus clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
m_req  input  N_MASTERS  per-master request; level, held until grant
m_write  input  N_MASTERS  per-master direction: 1 = write, 0 = read
m_slave_id  input  N_MASTERS*SID_W  per-master target slave id; master i occupies bits [i*SID_W +: SID_W]
s_done  input  N_SLAVES  per-slave completion pulse (slave_tx_done OR rx_done of each slave)
m_grant  output  N_MASTERS  one-hot grant; zero when no master holds the bus
s_read_en  output  N_SLAVES  one-hot read enable to the selected slave
s_write_en  output  N_SLAVES  one-hot write enable to the selected slave
bus_busy  output  1  high in GRANT and BUSY states
decode_err  output  1  one-cycle pulse when the granted slave id is >= N_SLAVES
timeout_err  output  1  one-cycle pulse on watchdog expiry (0 when ARB_TIMEOUT_EN is undefined)

Behaviour:
- Reset values (asserted asynchronously): all outputs 0, state IDLE, priority pointer = 0, latched id/direction = 0.
- States: IDLE, GRANT, BUSY, GAP.
- IDLE: if any m_req bit is set, pick the first requester at or after the pointer, wrapping modulo N_MASTERS. Latch its index, m_write and m_slave_id, then go to GRANT. Grant appears 1 cycle after req is sampled.
- GRANT:
  - Assert m_grant[idx].
  - If latched id < N_SLAVES: assert s_write_en[id] when write=1, else s_read_en[id]; go to BUSY.
  - Otherwise: pulse decode_err, enable no slave, go to GAP.
- BUSY: hold grant and enable. When s_done[latched id] = 1, go to GAP. s_done from any other slave is ignored. If the granted master drops m_req in BUSY, the grant is still held until done.
- GAP (1 cycle):
  - All grants and enables are 0 and bus_busy = 0.
  - Pointer := idx+1, wrapping N_MASTERS-1 -> 0.
  - Next state is IDLE, so back-to-back transfers are spaced by at least 2 idle cycles.
- Requests arriving while the bus is not in IDLE wait; no preemption.
- s_done in the same cycle as entering BUSY is not seen; done is sampled only in BUSY.
- Outputs are registered. m_grant and s_*_en change only on state transitions.
- Reset asserted mid-transfer: all outputs clear immediately (asynchronously). After release, the block starts in IDLE with pointer 0.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: a counter clears on entry to BUSY and increments each BUSY cycle. When it reaches TIMEOUT without s_done, pulse timeout_err for 1 cycle and go to GAP; the grant is revoked. Counter width = clog2(TIMEOUT+1).
- Undefined: no counter is built, timeout_err is tied 0, and BUSY waits indefinitely for s_done.

Test Plan:
- Reset then m_req=01, m_write=1, id0=2 -> m_grant=01 and s_write_en=100 one cycle after req. s_done[2] pulse -> next cycle GAP with all outputs 0, then IDLE.
- m_req=11 held, both read slave 1 -> grants alternate 01, 10, 01. Each grant ends on s_done[1]. Pointer wraps correctly.
- Master 0 granted to slave 0 -> pulse s_done[1] and s_done[2] -> grant held. s_done[0] releases it.
- m_slave_id=3 with N_SLAVES=3 -> one-cycle m_grant, decode_err=1, s_read_en=s_write_en=000, then GAP.
- Assert reset low during BUSY -> all outputs 0 with no clock edge. After release, m_req=10 -> master 1 granted; the pointer does not favour the previous holder.
- With ARB_TIMEOUT_EN and TIMEOUT=8: grant with no s_done -> timeout_err pulses after 8 BUSY cycles and the grant drops. Without the macro, the grant holds past 100 cycles.
